// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM skid register.
// Holds the payload struct, the FSM state enum and the ALU op encodings.
package ex_mem_pkg;

  localparam int N  = 32;
  localparam int RW = 5;
  localparam int CW = 3;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic [N-1:0]  y;
    logic          zero;
    logic          cout;
    logic [RW-1:0] wreg;
    logic [N-1:0]  wdata;
    logic [CW-1:0] ctrl;
    logic          ovf;
  } ex_mem_payload_t;

endpackage

// File: rtl/ovf_detect.sv
// Signed-overflow detector for the ALU add/subtract op.
// F[2] inverts B, so subtraction overflows when A and ~B share a sign.
module ovf_detect
  import ex_mem_pkg::*;
(
  input  logic [2:0] f,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       y_msb,
  output logic       ovf
);

  assign ovf = (f[1:0] == ALU_ADD) & (a_msb == (b_msb ^ f[2])) & (y_msb != a_msb);

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer and registered ex_ready.
// Define EX_MEM_OVF_EN to compute and carry the signed-overflow flag (mem_ovf).
module ex_mem_skid_reg
  import ex_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [N-1:0]  ex_y,
  input  logic          ex_zero,
  input  logic          ex_cout,
  input  logic [2:0]    ex_f,
  input  logic          ex_a_msb,
  input  logic          ex_b_msb,
  input  logic [RW-1:0] ex_wreg,
  input  logic [N-1:0]  ex_wdata,
  input  logic [CW-1:0] ex_ctrl,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [N-1:0]  mem_y,
  output logic          mem_zero,
  output logic          mem_cout,
  output logic [RW-1:0] mem_wreg,
  output logic [N-1:0]  mem_wdata,
  output logic [CW-1:0] mem_ctrl,
  output logic          mem_ovf
);

  skid_state_e     state_r, next_state_s;
  logic            ex_ready_r;
  ex_mem_payload_t main_r, skid_r, in_s;
  logic            ovf_s;
  logic            push_s, pop_s;
  logic            load_main_s, load_skid_s, promote_s;

`ifdef EX_MEM_OVF_EN
  ovf_detect u_ovf_detect (
    .f     (ex_f),
    .a_msb (ex_a_msb),
    .b_msb (ex_b_msb),
    .y_msb (ex_y[N-1]),
    .ovf   (ovf_s)
  );
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ^{ex_f, ex_a_msb, ex_b_msb};
  assign ovf_s        = 1'b0;
`endif

  assign in_s = '{y: ex_y, zero: ex_zero, cout: ex_cout, wreg: ex_wreg,
                  wdata: ex_wdata, ctrl: ex_ctrl, ovf: ovf_s};

  assign mem_valid = (state_r != EMPTY);
  assign push_s    = ex_valid & ex_ready_r;
  assign pop_s     = mem_valid & mem_ready;

  // Next-state and storage-load decode; flush overrides any push or pop.
  always_comb begin
    next_state_s = state_r;
    load_main_s  = 1'b0;
    load_skid_s  = 1'b0;
    promote_s    = 1'b0;
    if (flush) begin
      next_state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            next_state_s = ONE;
            load_main_s  = 1'b1;
          end else begin
            next_state_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && !pop_s) begin
            next_state_s = TWO;
            load_skid_s  = 1'b1;
          end else if (push_s && pop_s) begin
            next_state_s = ONE;
            load_main_s  = 1'b1;
          end else if (pop_s) begin
            next_state_s = EMPTY;
          end else begin
            next_state_s = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            next_state_s = ONE;
            promote_s    = 1'b1;
          end else begin
            next_state_s = TWO;
          end
        end
        default: begin
          next_state_s = EMPTY;
        end
      endcase
    end
  end

  // State register and registered ready (low only while both entries are full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      ex_ready_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      ex_ready_r <= (next_state_s != TWO);
    end
  end

  // Head entry: loaded from EX directly, or from skid when it is promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= '0;
    end else if (load_main_s) begin
      main_r <= in_s;
    end else if (promote_s) begin
      main_r <= skid_r;
    end else begin
      main_r <= main_r;
    end
  end

  // Overflow entry, written only when the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r <= '0;
    end else if (load_skid_s) begin
      skid_r <= in_s;
    end else begin
      skid_r <= skid_r;
    end
  end

  assign ex_ready  = ex_ready_r;
  assign mem_y     = main_r.y;
  assign mem_zero  = main_r.zero;
  assign mem_cout  = main_r.cout;
  assign mem_wreg  = main_r.wreg;
  assign mem_wdata = main_r.wdata;
  assign mem_ctrl  = main_r.ctrl;
  assign mem_ovf   = main_r.ovf;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus randomized traffic
// compared against a queue-based model (capacity two, ready = fewer than two held).
module tb_ex_mem_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_y;
  logic        ex_zero;
  logic        ex_cout;
  logic [2:0]  ex_f;
  logic        ex_a_msb;
  logic        ex_b_msb;
  logic [4:0]  ex_wreg;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_ctrl;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_y;
  logic        mem_zero;
  logic        mem_cout;
  logic [4:0]  mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ovf;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        cout;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        ovf;
  } item_t;

  item_t q[$];
  logic  model_ready;
  int    n_checks;
  int    n_pass;

  ex_mem_skid_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_y      (ex_y),
    .ex_zero   (ex_zero),
    .ex_cout   (ex_cout),
    .ex_f      (ex_f),
    .ex_a_msb  (ex_a_msb),
    .ex_b_msb  (ex_b_msb),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_ctrl   (ex_ctrl),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_y     (mem_y),
    .mem_zero  (mem_zero),
    .mem_cout  (mem_cout),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_ctrl  (mem_ctrl),
    .mem_ovf   (mem_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Signed overflow of an add (F[2]=0) or subtract (F[2]=1); other ops never overflow.
  function automatic logic exp_ovf(input logic [2:0] f, input logic a, input logic b,
                                   input logic [31:0] y);
`ifdef EX_MEM_OVF_EN
    logic b_eff;
    b_eff = f[2] ? ~b : b;
    return (f[1:0] == 2'b10) && (a == b_eff) && (y[31] != a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, mem_valid}, {31'd0, q.size() != 0});
    check({tag, "_ready"}, {31'd0, ex_ready}, {31'd0, model_ready});
    if (q.size() != 0) begin
      check({tag, "_y"},     mem_y, q[0].y);
      check({tag, "_wreg"},  {27'd0, mem_wreg}, {27'd0, q[0].wreg});
      check({tag, "_wdata"}, mem_wdata, q[0].wdata);
      check({tag, "_misc"},  {26'd0, mem_zero, mem_cout, mem_ctrl, mem_ovf},
                             {26'd0, q[0].zero, q[0].cout, q[0].ctrl, q[0].ovf});
    end
  endtask

  // One clock: apply mem_ready/flush with the current ex_* drive, advance the model, check.
  task automatic cycle(input logic mr, input logic fl, input string tag);
    logic  push, pop;
    item_t it;
    mem_ready = mr;
    flush     = fl;
    push = ex_valid && model_ready;
    pop  = (q.size() != 0) && mr;
    it = '{y: ex_y, zero: ex_zero, cout: ex_cout, wreg: ex_wreg, wdata: ex_wdata,
           ctrl: ex_ctrl, ovf: exp_ovf(ex_f, ex_a_msb, ex_b_msb, ex_y)};
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(it);
    end
    model_ready = (q.size() < 2);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic [4:0] wreg);
    ex_valid = v;
    ex_y     = y;
    ex_wreg  = wreg;
    ex_wdata = ~y;
    ex_zero  = (y == 32'd0);
    ex_cout  = y[0];
    ex_ctrl  = y[2:0];
    ex_f     = 3'b000;
    ex_a_msb = 1'b0;
    ex_b_msb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_y", mem_y, 32'd0);
    check("rst_ovf", {31'd0, mem_ovf}, 32'd0);
    q.delete();
    model_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    flush = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'd0, 5'd0);
    @(negedge clk);
    do_reset();

    // Single push, drained the next cycle.
    drive(1'b1, 32'h0000_0005, 5'd3);
    cycle(1'b1, 1'b0, "single");
    check("single_y5", mem_y, 32'd5);
    check("single_w3", {27'd0, mem_wreg}, 32'd3);
    drive(1'b0, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, "single_drain");
    check("single_empty", {31'd0, mem_valid}, 32'd0);

    // Back-pressure: 1 and 2 accepted, 3 held until space frees.
    drive(1'b1, 32'd1, 5'd1);
    cycle(1'b1, 1'b0, "bp0");
    drive(1'b1, 32'd2, 5'd2);
    cycle(1'b0, 1'b0, "bp1");
    check("bp_ready_low", {31'd0, ex_ready}, 32'd0);
    check("bp_head1", mem_y, 32'd1);
    drive(1'b1, 32'd3, 5'd3);
    cycle(1'b0, 1'b0, "bp2");
    check("bp_hold1", mem_y, 32'd1);
    cycle(1'b1, 1'b0, "bp3");
    check("bp_head2", mem_y, 32'd2);
    cycle(1'b1, 1'b0, "bp4");
    check("bp_head3", mem_y, 32'd3);
    drive(1'b0, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, "bp5");
    check("bp_empty", {31'd0, mem_valid}, 32'd0);

    // Flush in TWO with a simultaneous push.
    drive(1'b1, 32'h11, 5'd4);
    cycle(1'b0, 1'b0, "fl0");
    drive(1'b1, 32'h22, 5'd5);
    cycle(1'b0, 1'b0, "fl1");
    drive(1'b1, 32'hDEAD, 5'd6);
    cycle(1'b0, 1'b1, "fl2");
    check("fl_valid", {31'd0, mem_valid}, 32'd0);
    check("fl_ready", {31'd0, ex_ready}, 32'd1);
    drive(1'b0, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, "fl3");
    check("fl_nocap", {31'd0, mem_valid}, 32'd0);

    // Overflow: add of two positives giving a negative, then the same as subtract.
    drive(1'b1, 32'h8000_0000, 5'd7);
    ex_f = 3'b010;
    cycle(1'b1, 1'b0, "ovf_add");
`ifdef EX_MEM_OVF_EN
    check("ovf_add_set", {31'd0, mem_ovf}, 32'd1);
`else
    check("ovf_add_off", {31'd0, mem_ovf}, 32'd0);
`endif
    drive(1'b1, 32'h8000_0000, 5'd7);
    ex_f = 3'b110;
    cycle(1'b1, 1'b0, "ovf_sub");
    check("ovf_sub_clr", {31'd0, mem_ovf}, 32'd0);
    drive(1'b0, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, "ovf_drain");

    // Randomized traffic; EX holds its item while stalled.
    for (int i = 0; i < 400; i++) begin
      if (!(ex_valid && !ex_ready)) begin
        drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom));
        ex_wdata = $urandom;
        ex_f     = 3'($urandom);
        ex_a_msb = 1'($urandom);
        ex_b_msb = 1'($urandom);
      end
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, "rnd");
      if (i == 200) begin
        drive(1'b1, 32'h1234_5678, 5'd9);
        cycle(1'b0, 1'b0, "pre_rst");
        #2;
        do_reset();
        drive(1'b1, 32'h0000_00AA, 5'd10);
        cycle(1'b0, 1'b0, "post_rst");
        check("post_rst_y", mem_y, 32'hAA);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

EX→MEM pipeline register with a two-entry skid buffer. It captures each ALU result (Y, ZeroFlag, Cout) together with its destination register, store data and memory/writeback control, and hands it to the memory stage over a valid/ready handshake. Throughput is one result per cycle. Because `ex_ready` is a registered output, there is no combinational path from `mem_ready` back into the execute stage.

## Interface
- `N`, 32, ALU datapath width.
- `RW`, 5, destination register index width.
- `CW`, 3, control bundle width: {regwrite, memtoreg, memwrite}.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `flush`  in  1  synchronous pipeline flush.
- `ex_valid`  in  1  EX holds a valid result.
- `ex_ready`  out  1  block can accept a result (registered).
- `ex_y`  in  N  ALU result.
- `ex_zero`  in  1  ALU zero flag.
- `ex_cout`  in  1  ALU carry-out.
- `ex_f`  in  3  ALU function code (F[2] = invert B, F[1:0] = op).
- `ex_a_msb`, `ex_b_msb`  in  1 each  operand sign bits.
- `ex_wreg`  in  RW  destination register.
- `ex_wdata`  in  N  store data.
- `ex_ctrl`  in  CW  control bundle.
- `mem_valid`  out  1  head entry valid.
- `mem_ready`  in  1  MEM accepts the head entry.
- `mem_y`, `mem_zero`, `mem_cout`, `mem_wreg`, `mem_wdata`, `mem_ctrl`  out  head-entry payload (widths as the inputs).
- `mem_ovf`  out  1  signed overflow of the head entry.

## Operation
- Storage: `main` entry drives the `mem_*` outputs; `skid` entry holds overflow.
- FSM states: EMPTY, ONE (main valid), TWO (main and skid valid).
  - push = `ex_valid & ex_ready`.
  - pop = `mem_valid & mem_ready`.
- Transitions:
  - EMPTY, push → ONE; payload loads into main.
  - ONE, push & !pop → TWO; payload loads into skid.
  - ONE, push & pop → ONE; main loads the new payload.
  - ONE, pop only → EMPTY.
  - TWO, pop → ONE; skid moves to main. No push is possible in TWO because `ex_ready` = 0.
  - All other combinations hold state.
- `ex_ready` next value = 1 unless the next state is TWO.
- `mem_valid` = state ≠ EMPTY.
- Flush:
  - Next state is EMPTY and `ex_ready` is 1 next cycle.
  - Flush has priority over a push and a pop in the same cycle; neither is performed.
  - Payload registers may keep stale data. `mem_*` payload outputs are don't-care while `mem_valid` = 0.
- Payload is captured verbatim; no arithmetic is performed except the overflow computation.
- Overflow:
  - Computed at push time and stored with the payload: ovf = (`ex_f[1:0]` == 2'b10) & (`ex_a_msb` == (`ex_b_msb` ^ `ex_f[2]`)) & (`ex_y[N-1]` != `ex_a_msb`).
  - Logic ops (00, 01) and slt (11) always give 0.

## Timing
- Reset values:
  - state = EMPTY.
  - `ex_ready` = 1, `mem_valid` = 0, `mem_ovf` = 0.
  - All `mem_*` payload outputs = 0.
- Latency: a result pushed in cycle t is presented on `mem_*` with `mem_valid` = 1 in cycle t+1.
- Sustained rate is 1/cycle while `mem_ready` stays high.
- When `mem_ready` drops:
  - At most one extra result is absorbed into skid.
  - `ex_ready` falls in the cycle after that capture.
- After `mem_ready` returns, `ex_ready` rises one cycle after the skid entry is promoted.
- Handshake rules:
  - `mem_*` outputs are stable while `mem_valid` & !`mem_ready`.
  - EX must hold `ex_*` stable while `ex_valid` & !`ex_ready`.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). The first push is accepted on the first rising edge after `rst_n` deasserts.

## Configuration
- Macro: `EX_MEM_OVF_EN`.
- Defined:
  - Overflow is computed per the Operation formula.
  - One extra flop in each of main and skid.
  - `mem_ovf` reflects the head entry.
- Undefined:
  - `mem_ovf` is tied to 0.
  - `ex_f`, `ex_a_msb` and `ex_b_msb` are ignored.
  - No overflow flops are inferred.
- The port list is identical in both builds.

## Structure
- Shared package `ex_mem_pkg`:
  - `ex_mem_payload_t` packed struct {y, zero, cout, wreg, wdata, ctrl, ovf}.
  - `skid_state_e` enum {EMPTY, ONE, TWO}.
  - ALU op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SLT` (2'b00..2'b11).
- Sub-module `ovf_detect`: combinational overflow formula. Instantiated only under `EX_MEM_OVF_EN`.

## Test plan
- Reset with `rst_n` = 0 mid-stream → `mem_valid` = 0, `ex_ready` = 1, `mem_y` = 0 immediately.
- Push `ex_y` = 0x0000_0005, `ex_wreg` = 3 with `mem_ready` = 1 → next cycle `mem_valid` = 1, `mem_y` = 5, `mem_wreg` = 3. The following cycle `mem_valid` = 0.
- Push values 1, 2, 3 on consecutive cycles with `mem_ready` = 0 from the second cycle:
  - 1 and 2 are accepted.
  - `ex_ready` = 0 before 3 is accepted.
  - Raise `mem_ready` → outputs 1, 2, then 3 in order, with no loss or duplication.
- Flush while in TWO, with a simultaneous `ex_valid` → next cycle `mem_valid` = 0, `ex_ready` = 1, and the flushed push is not captured.
- With the macro defined, push `ex_f` = 3'b010, `ex_a_msb` = 0, `ex_b_msb` = 0, `ex_y` = 0x8000_0000 → `mem_ovf` = 1. The same push with `ex_f` = 3'b110 → `mem_ovf` = 0.
- With the macro undefined, repeat the overflow stimulus → `mem_ovf` = 0 throughout.
